// File: rtl/fpga_status_pkg.sv
// Shared types, default cycle constants and helpers for the board status controller.
package fpga_status_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PASS,
    BLINK_ON,
    BLINK_OFF,
    PAUSE
  } status_state_e;

  localparam int DEF_HB_CNT_WIDTH       = 27;
  localparam int DEF_RST_STRETCH_CYCLES = 16;
  localparam int DEF_EXIT_CODE_WIDTH    = 8;
  localparam int DEF_MAX_BLINKS         = 15;
  localparam int DEF_BLINK_ON_CYCLES    = 2**24;
  localparam int DEF_BLINK_OFF_CYCLES   = 2**24;
  localparam int DEF_PAUSE_CYCLES       = 2**26;

  function automatic logic [31:0] clamp_blinks(input logic [31:0] code, input int max_blinks);
    return (code > 32'(max_blinks)) ? 32'(max_blinks) : code;
  endfunction

endpackage

// File: rtl/fpga_rst_stretch.sv
// Holds rst_hold high for CYCLES rising edges after rst_req deasserts.
module fpga_rst_stretch #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst_req,
  output logic rst_hold
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // A new request at any point restarts the count from zero.
  always_ff @(posedge clk) begin
    if (rst_req) begin
      cnt      <= '0;
      rst_hold <= 1'b1;
    end else if (rst_hold) begin
      if (cnt == CW'(CYCLES - 1)) rst_hold <= 1'b0;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fpga_board_status_ctrl.sv
// Board reset stretch, heartbeat and exit-code blink display.
// Optional GPIO-to-LED mirror enabled by defining FPGA_STATUS_GPIO_MIRROR_EN.
module fpga_board_status_ctrl
  import fpga_status_pkg::*;
#(
  parameter int HB_CNT_WIDTH       = DEF_HB_CNT_WIDTH,
  parameter int RST_STRETCH_CYCLES = DEF_RST_STRETCH_CYCLES,
  parameter int EXIT_CODE_WIDTH    = DEF_EXIT_CODE_WIDTH,
  parameter int MAX_BLINKS         = DEF_MAX_BLINKS,
  parameter int BLINK_ON_CYCLES    = DEF_BLINK_ON_CYCLES,
  parameter int BLINK_OFF_CYCLES   = DEF_BLINK_OFF_CYCLES,
  parameter int PAUSE_CYCLES       = DEF_PAUSE_CYCLES
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       exit_valid_i,
  input  logic [31:0]                exit_value_i,
  input  logic [1:0]                 gpio_mirror_i,
  output logic                       rst_o,
  output logic                       hb_led_o,
  output logic                       rst_led_o,
  output logic                       status_led_o,
  output logic [1:0]                 aux_led_o,
  output logic [EXIT_CODE_WIDTH-1:0] exit_code_o,
  output logic                       done_o
);

  localparam int MAX_PH = (BLINK_ON_CYCLES > BLINK_OFF_CYCLES)
                          ? ((BLINK_ON_CYCLES > PAUSE_CYCLES) ? BLINK_ON_CYCLES : PAUSE_CYCLES)
                          : ((BLINK_OFF_CYCLES > PAUSE_CYCLES) ? BLINK_OFF_CYCLES : PAUSE_CYCLES);
  localparam int TW = $clog2(MAX_PH) + 1;
  localparam int BW = $clog2(MAX_BLINKS + 1);

  localparam logic [TW-1:0] ON_LD    = TW'(BLINK_ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD   = TW'(BLINK_OFF_CYCLES - 1);
  localparam logic [TW-1:0] PAUSE_LD = TW'(PAUSE_CYCLES - 1);

  logic                       rst_q;
  logic                       hold;
  logic [HB_CNT_WIDTH-1:0]    hb_cnt;
  status_state_e              state;
  logic [TW-1:0]              timer;
  logic [BW-1:0]              blinks;
  logic [BW-1:0]              remain;
  logic                       valid_q;
  logic                       capture;
  logic [EXIT_CODE_WIDTH-1:0] new_code;
  logic [BW-1:0]              new_blinks;
  logic                       unused_in;

  fpga_rst_stretch #(.CYCLES(RST_STRETCH_CYCLES)) u_rst_stretch (
    .clk      (clk_i),
    .rst_req  (rst_i),
    .rst_hold (rst_q)
  );

  // rst_i is folded in so every register clears on the same edge rst_q rises.
  assign hold      = rst_i | rst_q;
  assign rst_o     = rst_q;
  assign rst_led_o = rst_q;

  always_ff @(posedge clk_i) begin
    if (hold) hb_cnt <= '0;
    else      hb_cnt <= hb_cnt + HB_CNT_WIDTH'(1);
  end

  assign hb_led_o = hb_cnt[HB_CNT_WIDTH-1];

  assign capture    = exit_valid_i & ~valid_q;
  assign new_code   = exit_value_i[EXIT_CODE_WIDTH-1:0];
  assign new_blinks = BW'(clamp_blinks(32'(new_code), MAX_BLINKS));
  assign unused_in  = ^{exit_value_i, gpio_mirror_i};

  always_ff @(posedge clk_i) begin
    if (hold) begin
      state        <= IDLE;
      status_led_o <= 1'b0;
      done_o       <= 1'b0;
      exit_code_o  <= '0;
      blinks       <= '0;
      remain       <= '0;
      timer        <= '0;
      valid_q      <= 1'b0;
    end else begin
      valid_q <= exit_valid_i;
      // Clear has priority, so a coincident capture edge is dropped.
      if (clear_i) begin
        state        <= IDLE;
        status_led_o <= 1'b0;
        done_o       <= 1'b0;
        exit_code_o  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (capture) begin
              exit_code_o  <= new_code;
              done_o       <= 1'b1;
              status_led_o <= 1'b1;
              if (new_code == '0) begin
                state <= PASS;
              end else begin
                state  <= BLINK_ON;
                blinks <= new_blinks;
                remain <= new_blinks;
                timer  <= ON_LD;
              end
            end
          end
          PASS: status_led_o <= 1'b1;
          BLINK_ON: begin
            if (timer == '0) begin
              remain       <= remain - BW'(1);
              status_led_o <= 1'b0;
              if (remain > BW'(1)) begin
                state <= BLINK_OFF;
                timer <= OFF_LD;
              end else begin
                state <= PAUSE;
                timer <= PAUSE_LD;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end
          BLINK_OFF: begin
            if (timer == '0) begin
              state        <= BLINK_ON;
              status_led_o <= 1'b1;
              timer        <= ON_LD;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          PAUSE: begin
            if (timer == '0) begin
              state        <= BLINK_ON;
              status_led_o <= 1'b1;
              remain       <= blinks;
              timer        <= ON_LD;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: begin
            state        <= IDLE;
            status_led_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FPGA_STATUS_GPIO_MIRROR_EN
  always_ff @(posedge clk_i) begin
    if (hold) aux_led_o <= '0;
    else      aux_led_o <= gpio_mirror_i;
  end
`else
  assign aux_led_o = '0;
`endif

endmodule

// File: tb/tb_fpga_board_status_ctrl.sv
// Randomized self-checking bench for fpga_board_status_ctrl against a timing-rule model.
module tb_fpga_board_status_ctrl;

  localparam int RST_N = 4;
  localparam int ON    = 3;
  localparam int OFF   = 2;
  localparam int PAUSE = 5;
  localparam int MAXB  = 15;
  localparam int HBW   = 4;
  localparam int EW    = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          exit_valid_i = 1'b0;
  logic [31:0]   exit_value_i = '0;
  logic [1:0]    gpio_mirror_i = '0;
  logic          rst_o, hb_led_o, rst_led_o, status_led_o, done_o;
  logic [1:0]    aux_led_o;
  logic [EW-1:0] exit_code_o;

  int cmp_cnt = 0;
  int err_cnt = 0;

  fpga_board_status_ctrl #(
    .HB_CNT_WIDTH(HBW), .RST_STRETCH_CYCLES(RST_N), .EXIT_CODE_WIDTH(EW),
    .MAX_BLINKS(MAXB), .BLINK_ON_CYCLES(ON), .BLINK_OFF_CYCLES(OFF), .PAUSE_CYCLES(PAUSE)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i), .gpio_mirror_i(gpio_mirror_i), .rst_o(rst_o),
    .hb_led_o(hb_led_o), .rst_led_o(rst_led_o), .status_led_o(status_led_o),
    .aux_led_o(aux_led_o), .exit_code_o(exit_code_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LED level k cycles after the capture edge: n blinks of ON, separated by OFF, then PAUSE.
  function automatic logic exp_led(input int n, input int k);
    int train, period, p;
    if (n == 0) return 1'b1;
    train  = n * ON + (n - 1) * OFF;
    period = train + PAUSE;
    p      = k % period;
    if (p >= train) return 1'b0;
    return (p % (ON + OFF)) < ON;
  endfunction

  task automatic do_reset();
    clear_i = 1'b0; exit_valid_i = 1'b0; rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (RST_N) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    cmp_cnt++;
    if ({rst_o, rst_led_o, hb_led_o, status_led_o, aux_led_o, exit_code_o, done_o} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_outputs: got rst=%b rled=%b hb=%b st=%b aux=%b code=%h done=%b",
               rst_o, rst_led_o, hb_led_o, status_led_o, aux_led_o, exit_code_o, done_o);
    end
  endtask

  task automatic test_stretch();
    logic exp;
    rst_i = 1'b1; repeat (3) tick();
    rst_i = 1'b0;
    for (int k = 1; k <= RST_N; k++) begin
      tick();
      exp = (k < RST_N);
      cmp_cnt++;
      if (rst_o !== exp || rst_led_o !== exp) begin
        err_cnt++;
        $display("FAIL stretch_edge%0d: rst_o=%b rst_led=%b want %b", k, rst_o, rst_led_o, exp);
      end
    end
    rst_i = 1'b1; tick();
    rst_i = 1'b0; tick();
    rst_i = 1'b1; tick();
    rst_i = 1'b0;
    for (int k = 1; k <= RST_N; k++) begin
      tick();
      exp = (k < RST_N);
      cmp_cnt++;
      if (rst_o !== exp) begin
        err_cnt++;
        $display("FAIL stretch_restart_edge%0d: rst_o=%b want %b", k, rst_o, exp);
      end
    end
  endtask

  task automatic test_heartbeat();
    logic exp;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp = ((k % (1 << HBW)) >= (1 << (HBW - 1)));
      cmp_cnt++;
      if (hb_led_o !== exp) begin
        err_cnt++;
        $display("FAIL heartbeat_k%0d: hb=%b want %b", k, hb_led_o, exp);
      end
    end
  endtask

  task automatic test_blink(input logic [31:0] code, input int cycles);
    int n;
    logic [EW-1:0] ecode;
    ecode = code[EW-1:0];
    n = (int'(ecode) > MAXB) ? MAXB : int'(ecode);
    exit_value_i = code; exit_valid_i = 1'b1;
    tick();
    cmp_cnt++;
    if (done_o !== 1'b1 || exit_code_o !== ecode) begin
      err_cnt++;
      $display("FAIL capture_%h: done=%b code=%h want done=1 code=%h", code, done_o, exit_code_o, ecode);
    end
    for (int k = 0; k < cycles; k++) begin
      cmp_cnt++;
      if (status_led_o !== exp_led(n, k)) begin
        err_cnt++;
        $display("FAIL pattern_%h_k%0d: led=%b want %b", code, k, status_led_o, exp_led(n, k));
      end
      tick();
    end
    clear_i = 1'b1; exit_valid_i = 1'b0;
    tick();
    clear_i = 1'b0;
    cmp_cnt++;
    if ({done_o, exit_code_o, status_led_o} !== {1'b0, 8'h00, 1'b0}) begin
      err_cnt++;
      $display("FAIL clear_after_%h: done=%b code=%h led=%b want 0/00/0", code, done_o, exit_code_o, status_led_o);
    end
    tick();
  endtask

  task automatic test_clear();
    exit_value_i = 32'd3; exit_valid_i = 1'b1;
    repeat (4) tick();
    cmp_cnt++;
    if (status_led_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL clear_setup_off: led=%b want 0", status_led_o);
    end
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    cmp_cnt++;
    if ({done_o, exit_code_o, status_led_o} !== {1'b0, 8'h00, 1'b0}) begin
      err_cnt++;
      $display("FAIL clear_in_off: done=%b code=%h led=%b want 0/00/0", done_o, exit_code_o, status_led_o);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      cmp_cnt++;
      if (done_o !== 1'b0 || status_led_o !== 1'b0) begin
        err_cnt++;
        $display("FAIL clear_no_retrigger_k%0d: done=%b led=%b want 0/0", k, done_o, status_led_o);
      end
    end
    exit_valid_i = 1'b0; tick();
    test_blink(32'd5, 60);
  endtask

  task automatic test_clear_edge();
    exit_valid_i = 1'b0; tick();
    exit_value_i = 32'd7; exit_valid_i = 1'b1; clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    repeat (10) tick();
    cmp_cnt++;
    if (done_o !== 1'b0 || status_led_o !== 1'b0 || exit_code_o !== 8'h00) begin
      err_cnt++;
      $display("FAIL clear_edge_same_cycle: done=%b led=%b code=%h want 0/0/00", done_o, status_led_o, exit_code_o);
    end
    exit_valid_i = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    exit_value_i = 32'd4; exit_valid_i = 1'b1; tick();
    exit_valid_i = 1'b0; tick();
    exit_value_i = 32'd9; exit_valid_i = 1'b1; tick();
    cmp_cnt++;
    if (exit_code_o !== 8'd4 || done_o !== 1'b1 || status_led_o !== exp_led(4, 2)) begin
      err_cnt++;
      $display("FAIL second_edge_ignored: code=%h done=%b led=%b want 04/1/%b", exit_code_o, done_o, status_led_o, exp_led(4, 2));
    end
    clear_i = 1'b1; exit_valid_i = 1'b0; tick();
    clear_i = 1'b0; tick();
  endtask

  task automatic test_random();
    logic [31:0] code;
    int n;
    for (int i = 0; i < 8; i++) begin
      code = $urandom;
      if ($urandom_range(0, 3) != 0) code[7:0] = 8'($urandom_range(0, 20));
      n = (int'(code[7:0]) > MAXB) ? MAXB : int'(code[7:0]);
      test_blink(code, (n == 0) ? 20 : 2 * (n * ON + (n - 1) * OFF + PAUSE) + 3);
    end
  endtask

  task automatic test_mirror();
    logic [1:0] g, exp;
    for (int i = 0; i < 9; i++) begin
      g = (i == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      gpio_mirror_i = g;
      tick();
`ifdef FPGA_STATUS_GPIO_MIRROR_EN
      exp = g;
`else
      exp = 2'b00;
`endif
      cmp_cnt++;
      if (aux_led_o !== exp) begin
        err_cnt++;
        $display("FAIL mirror_%0d: aux=%b want %b", i, aux_led_o, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stretch();
    test_heartbeat();
    test_blink(32'h0, 100);
    test_blink(32'd3, 40);
    test_blink(32'h1FF, 160);
    test_clear();
    test_clear_edge();
    test_back_to_back();
    test_random();
    test_mirror();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
